// File: rtl/elastic_pipe_stage_if.sv
// rtl/elastic_pipe_stage_if.sv - valid/ready beat channel carrying payload and control
interface elastic_pipe_stage_if #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/elastic_pipe_stage.sv
// rtl/elastic_pipe_stage.sv - elastic pipeline register with 2-entry skid buffer
module elastic_pipe_stage #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   input  logic                 stall_clr_i,
   elastic_pipe_stage_if.slave  up_if,
   elastic_pipe_stage_if.master dn_if,
   output logic [1:0]           occupancy_o,
   output logic [CNT_W-1:0]     stall_cnt_o
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              valid_q, ready_q;
   logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              push, pop;

   assign push = up_if.valid & ready_q;
   assign pop  = valid_q & dn_if.ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               main_data_d = up_if.data;
               main_ctrl_d = up_if.ctrl;
               state_d     = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               main_data_d = up_if.data;
               main_ctrl_d = up_if.ctrl;
            end else if (push) begin
               skid_data_d = up_if.data;
               skid_ctrl_d = up_if.ctrl;
               state_d     = FULL;
            end else if (pop) begin
               // payload lingers in the bubble, control must not
               main_ctrl_d = '0;
               state_d     = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
               state_d     = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush_i) begin
         state_d     = EMPTY;
         main_data_d = '0;
         main_ctrl_d = '0;
         skid_data_d = '0;
         skid_ctrl_d = '0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (stall_clr_i) begin
         stall_d = '0;
      end else if (valid_q && !dn_if.ready && stall_q != {CNT_W{1'b1}}) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         valid_q     <= 1'b0;
         ready_q     <= 1'b1;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= (state_d != EMPTY);
         ready_q     <= (state_d != FULL);
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         stall_q     <= stall_d;
      end
   end

   assign up_if.ready = ready_q;
   assign dn_if.valid = valid_q;
   assign dn_if.data  = main_data_q;
   assign dn_if.ctrl  = main_ctrl_q;
   assign occupancy_o = state_q;
   assign stall_cnt_o = stall_q;
endmodule

// File: doc/elastic_pipe_stage.md
Name: elastic_pipe_stage

Overview:
- Parametrised, valid/ready elastic pipeline register for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces fixed enable/flush stage registers.
- A 2-entry skid buffer (main + skid) makes in_ready a pure register output, so backpressure never forms a combinational path upstream.
- Control bits are zeroed whenever the stage holds a bubble, and a saturating stall counter supports performance monitoring.

Parameters:
- DATA_W, 64, width of the payload (operands, addresses, rd, etc.); passed through, never zeroed except on reset/flush.
- CTRL_W, 8, width of the control field (RW, MR, MW, branch, is_muldiv, ...); forced to 0 when out_valid=0.
- CNT_W, 16, width of the stall counter.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, synchronous reset, active-high.
- flush, input, 1, synchronous squash of all held entries.
- in_valid, input, 1, upstream has a beat.
- in_ready, output, 1, stage accepts a beat; registered.
- in_data, input, DATA_W, upstream payload.
- in_ctrl, input, CTRL_W, upstream control bits.
- out_valid, output, 1, main entry holds a beat.
- out_ready, input, 1, downstream accepts.
- out_data, output, DATA_W, main entry payload.
- out_ctrl, output, CTRL_W, main entry control; 0 when out_valid=0.
- occupancy, output, 2, entries held: 0, 1 or 2.
- stall_cnt, output, CNT_W, saturating count of cycles with out_valid=1 and out_ready=0.
- stall_clr, input, 1, synchronous clear of stall_cnt.

Behaviour:
- **Handshake terms.** push = in_valid & in_ready; pop = out_valid & out_ready. Both are sampled at the rising edge.
- **Reset** (rst=1 at an edge) sets:
  - out_valid=0, out_data=0, out_ctrl=0
  - skid entry = 0, occupancy=0
  - in_ready=1, stall_cnt=0
- **Priority:** rst > flush > normal operation.
- **Latency:** a beat pushed at edge N is visible on the outputs after edge N when the stage was empty. Beats leave in strict FIFO order.
- **State EMPTY** (occ 0, in_ready=1):
  - push → main<=in, go to ONE.
  - Otherwise hold.
- **State ONE** (occ 1, in_ready=1):
  - push & pop → main<=in, stay in ONE.
  - push only → skid<=in, go to FULL; in_ready=0 after this edge.
  - pop only → go to EMPTY.
  - Neither → hold.
- **State FULL** (occ 2, in_ready=0):
  - pop → main<=skid, go to ONE; in_ready=1 after this edge.
  - Otherwise hold. No push is possible.
- **Drop/duplicate rule:** no beat is ever dropped or duplicated. In_valid while in_ready=0 has no effect. Upstream holds its data until it is accepted.
- **flush=1 at an edge:**
  - occupancy<=0, out_valid<=0, out_ctrl<=0, in_ready<=1.
  - Any push or pop on that edge is discarded. Downstream must not treat a pop on a flush edge as a completed transfer beyond that cycle.
  - out_data is zeroed.
  - stall_cnt is unaffected.
- **Bubble rule:** when out_valid=0, out_ctrl=0 always. out_data holds its last value except after reset/flush.
- **out_valid** is 1 exactly when occupancy ≥ 1. It is registered, with no combinational path from in_* to out_*.
- **in_ready** is 1 exactly when occupancy ≤ 1. It has no combinational path from out_ready.
- **stall_cnt:**
  - Increments by 1 at each edge where out_valid=1 and out_ready=0.
  - Saturates at all-ones.
  - stall_clr=1 sets it to 0, with priority over increment. rst also clears it.
- **Hold:** with in_valid=0 and out_ready=0, the state is fully held indefinitely.

Test Plan:
1. **Reset & bubble.**
   - Stimulus: rst=1 for 2 cycles, then in_valid=0.
   - Required: out_valid=0, out_ctrl=0, in_ready=1, occupancy=0, stall_cnt=0.
2. **Streaming.**
   - Stimulus: out_ready=1; push data 0x11,0x22,0x33 on consecutive cycles with ctrl=0x05.
   - Required: each beat appears 1 cycle later in order; occupancy stays 1; in_ready never drops.
3. **Backpressure/skid.**
   - Stimulus: out_ready=0; push 0xA1 then 0xA2.
   - Required after the second edge: occupancy=2, in_ready=0. Further in_valid with 0xA3 is ignored.
   - Then out_ready=1: 0xA1 pops, then 0xA2; 0xA3 is accepted once in_ready=1.
   - stall_cnt equals the number of stalled cycles.
4. **Flush mid-operation.**
   - Stimulus: in the FULL state, assert flush together with in_valid (0xB0) and out_ready=1.
   - Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. 0xB0 is never output.
5. **Saturation/clear.**
   - Stimulus: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles.
   - Required: stall_cnt=15. Then stall_clr=1 for 1 cycle → stall_cnt=0.
6. **Reset priority.**
   - Stimulus: rst=1 together with flush=1 and a push in state ONE.
   - Required: all reset values, including stall_cnt=0.
